pyrm_branch_unit: RTL and testbench
===================================

PYRM_BRANCH_UNIT -- requirements
Module: pyrm_branch_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; no parameters.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 reset_pyri  in  1  synchronous active-high reset.
REQ-004 pc_pyri  in  64  PC of offered instruction, from fetch.
REQ-005 pc_valid_pyri  in  1  PC valid.
REQ-006 pc_retry_pyro  out  1  PC not accepted this cycle.
REQ-007 inst_pyri  in  32  instruction word, from fetch.
REQ-008 inst_valid_pyri  in  1  instruction valid.
REQ-009 inst_retry_pyro  out  1  instruction not accepted; always equals pc_retry_pyro.
REQ-010 rs1_addr_pyro  out  5  inst[19:15] of held instruction.
REQ-011 rs2_addr_pyro  out  5  inst[24:20] of held instruction.
REQ-012 rs1_data_pyri  in  64  rs1 value, same-cycle combinational read.
REQ-013 rs2_data_pyri  in  64  rs2 value, same-cycle combinational read.
REQ-014 rs_ready_pyri  in  1  rs1/rs2 data current (no pending writer).
REQ-015 branch_pc_pyro  out  64  resolved next PC, to fetch.
REQ-016 branch_pc_valid_pyro  out  1  branch_pc valid.
REQ-017 branch_pc_retry_pyri  in  1  fetch cannot take branch_pc.
REQ-018 dec_pc_pyro  out  64  PC forwarded downstream.
REQ-019 dec_inst_pyro  out  32  instruction forwarded downstream.
REQ-020 dec_valid_pyro  out  1  forwarded pair valid.
REQ-021 dec_retry_pyri  in  1  downstream stall.

Function
REQ-022 Transfer on any channel SHALL occur exactly when valid=1 and retry=0 in the same cycle.
REQ-023 Input accepted only when pc_valid_pyri and inst_valid_pyri both 1 and retry 0; captured into a one-entry holding register.
REQ-024 retry SHALL be 1 when holding register full, except when it is non-control and dec transfer occurs that cycle (back-to-back, one instruction per cycle); retry SHALL NOT depend on pc/inst valid.
REQ-025 Class: opcode 1100011 BRANCH, 1100111 JALR = control; all others, incl. JAL 1101111 and unknown opcodes, = non-control.
REQ-026 Non-control: dec_valid_pyro=1 cycle after capture; no branch_pc issued.
REQ-027 States: EMPTY, HOLD, RESOLVE, SEND; EMPTY->HOLD on non-control capture, EMPTY->RESOLVE on control capture.
REQ-028 RESOLVE: while rs_ready_pyri=0 remain; when 1, register target, go to SEND next cycle (branch_pc_valid earliest 2 cycles after capture).
REQ-029 BRANCH target: taken -> pc+sext(B-imm {inst[31],inst[7],inst[30:25],inst[11:8],0}); not taken -> pc+4; 64-bit wrap, no overflow flag.
REQ-030 funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE signed; 110 BLTU, 111 BGEU unsigned; 010/011 -> not taken.
REQ-031 JALR target = (rs1+sext(inst[31:20])) with bit0 cleared.
REQ-032 SEND: branch_pc_valid_pyro=1, value stable until transfer; dec_valid_pyro=1 concurrently; each channel completes independently, tracked by done bit.
REQ-033 Control entry SHALL leave SEND only when both channels done; if input also offered that cycle, accept it (SEND->HOLD/RESOLVE), else ->EMPTY.
REQ-034 Exactly one branch_pc transfer per control instruction; none for any other.

Reset
REQ-035 While reset_pyri=1: state EMPTY, holding register invalid, done bits 0, dec_valid_pyro=0, branch_pc_valid_pyro=0, retries 1; data outputs 0.
REQ-036 Reset mid-RESOLVE/SEND SHALL discard the held instruction with no branch_pc transfer after reset deasserts.

Structure
REQ-037 Opcode/funct3 constants, state enum and 64'h80000000 reset PC SHALL live in shared package pyrm_pkg.
REQ-038 Comparator and target arithmetic SHALL be sub-module pyrm_branch_cmp (combinational, 64-bit).

Verification
REQ-039 Three ADDI at 0x80000000/4/8, dec_retry=0 -> dec_valid on 3 consecutive cycles, pc_retry never 1, no branch_pc.
REQ-040 BEQ x1,x2,+16 at 0x80000010, rs1=rs2=5 -> branch_pc=0x80000020; rs1=5,rs2=6 -> 0x80000014.
REQ-041 BLT rs1=-1, rs2=1 -> taken; BLTU same operands -> not taken.
REQ-042 JALR imm=3, rs1=0x80001000, rs_ready=0 for 4 cycles -> branch_pc_valid only after rs_ready, value 0x80001002.
REQ-043 BNE taken, branch_pc_retry=1 for 5 cycles, dec_retry=0 -> branch_pc stable, pc_retry=1 until branch transfer, exactly one transfer.
REQ-044 Reset asserted in SEND -> branch_pc_valid=0, dec_valid=0 next cycle, retries 1 during reset.

Source files
------------

// File: rtl/pyrm_pkg.sv
// ---------------------------------------------------------------------------
// pyrm_pkg
// Shared definitions for the branch unit: RISC-V opcode and funct3 encodings
// used to classify and resolve control instructions, the branch-unit state
// enum, and the architectural reset PC.
// ---------------------------------------------------------------------------
package pyrm_pkg;

   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
   localparam logic [6:0]  OPC_JALR   = 7'b1100111;

   localparam logic [2:0]  F3_BEQ  = 3'b000;
   localparam logic [2:0]  F3_BNE  = 3'b001;
   localparam logic [2:0]  F3_BLT  = 3'b100;
   localparam logic [2:0]  F3_BGE  = 3'b101;
   localparam logic [2:0]  F3_BLTU = 3'b110;
   localparam logic [2:0]  F3_BGEU = 3'b111;

   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RESOLVE = 2'd2,
      ST_SEND    = 2'd3
   } state_t;

   // Only conditional branches and JALR need operand-dependent resolution;
   // JAL and everything else flow straight through to decode.
   function automatic logic is_control(input logic [6:0] opc);
      return (opc == OPC_BRANCH) || (opc == OPC_JALR);
   endfunction

endpackage

// File: rtl/pyrm_branch_unit_if.sv
// ---------------------------------------------------------------------------
// pyrm_branch_unit_if
// Bundles the fetch, register-file, branch-redirect and decode channels of
// the branch unit.
//   slave  : the branch unit side
//   master : the surrounding pipeline (fetch / regfile / decode)
// ---------------------------------------------------------------------------
interface pyrm_branch_unit_if;
   logic [63:0] pc_pyri;
   logic        pc_valid_pyri;
   logic        pc_retry_pyro;
   logic [31:0] inst_pyri;
   logic        inst_valid_pyri;
   logic        inst_retry_pyro;
   logic [4:0]  rs1_addr_pyro;
   logic [4:0]  rs2_addr_pyro;
   logic [63:0] rs1_data_pyri;
   logic [63:0] rs2_data_pyri;
   logic        rs_ready_pyri;
   logic [63:0] branch_pc_pyro;
   logic        branch_pc_valid_pyro;
   logic        branch_pc_retry_pyri;
   logic [63:0] dec_pc_pyro;
   logic [31:0] dec_inst_pyro;
   logic        dec_valid_pyro;
   logic        dec_retry_pyri;

   modport slave (
      input  pc_pyri, pc_valid_pyri, inst_pyri, inst_valid_pyri,
             rs1_data_pyri, rs2_data_pyri, rs_ready_pyri,
             branch_pc_retry_pyri, dec_retry_pyri,
      output pc_retry_pyro, inst_retry_pyro, rs1_addr_pyro, rs2_addr_pyro,
             branch_pc_pyro, branch_pc_valid_pyro,
             dec_pc_pyro, dec_inst_pyro, dec_valid_pyro
   );

   modport master (
      output pc_pyri, pc_valid_pyri, inst_pyri, inst_valid_pyri,
             rs1_data_pyri, rs2_data_pyri, rs_ready_pyri,
             branch_pc_retry_pyri, dec_retry_pyri,
      input  pc_retry_pyro, inst_retry_pyro, rs1_addr_pyro, rs2_addr_pyro,
             branch_pc_pyro, branch_pc_valid_pyro,
             dec_pc_pyro, dec_inst_pyro, dec_valid_pyro
   );
endinterface

// File: rtl/pyrm_branch_cmp.sv
// ---------------------------------------------------------------------------
// pyrm_branch_cmp
// Combinational 64-bit branch comparator and next-PC calculator.
//   i_pc        PC of the held control instruction
//   i_rs1/rs2   register operands
//   i_is_jalr   1 = JALR, 0 = conditional branch
//   i_funct3    branch condition select
//   i_imm_i     I-type immediate (JALR offset)
//   i_imm_b     B-type immediate, bit0 always zero
//   o_target    resolved next PC (64-bit wraparound)
// ---------------------------------------------------------------------------
module pyrm_branch_cmp
   import pyrm_pkg::*;
(
   input  logic [63:0] i_pc,
   input  logic [63:0] i_rs1,
   input  logic [63:0] i_rs2,
   input  logic        i_is_jalr,
   input  logic [2:0]  i_funct3,
   input  logic [11:0] i_imm_i,
   input  logic [12:0] i_imm_b,
   output logic [63:0] o_target
);

   logic signed [63:0] w_rs1_s;
   logic signed [63:0] w_rs2_s;
   logic [63:0]        w_imm_b_sext;
   logic [63:0]        w_imm_i_sext;
   logic [63:0]        w_jalr_sum;
   logic               w_taken;

   assign w_rs1_s      = i_rs1;
   assign w_rs2_s      = i_rs2;
   assign w_imm_b_sext = {{51{i_imm_b[12]}}, i_imm_b};
   assign w_imm_i_sext = {{52{i_imm_i[11]}}, i_imm_i};
   assign w_jalr_sum   = i_rs1 + w_imm_i_sext;

   always_comb begin
      w_taken = 1'b0;
      case (i_funct3)
         F3_BEQ:  w_taken = (i_rs1 == i_rs2);
         F3_BNE:  w_taken = (i_rs1 != i_rs2);
         F3_BLT:  w_taken = (w_rs1_s <  w_rs2_s);
         F3_BGE:  w_taken = (w_rs1_s >= w_rs2_s);
         F3_BLTU: w_taken = (i_rs1 <  i_rs2);
         F3_BGEU: w_taken = (i_rs1 >= i_rs2);
         default: w_taken = 1'b0;   // 010/011 are not branch conditions
      endcase
   end

   // JALR clears bit 0 of the sum so the redirect is always halfword aligned.
   assign o_target = i_is_jalr ? {w_jalr_sum[63:1], 1'b0}
                   : (w_taken ? (i_pc + w_imm_b_sext) : (i_pc + 64'd4));

endmodule

// File: rtl/pyrm_branch_unit.sv
// ---------------------------------------------------------------------------
// pyrm_branch_unit
// One-entry holding stage between fetch and decode that resolves control
// instructions (conditional branches, JALR) and redirects fetch.
//   clk         sole clock, rising edge
//   reset_pyri  synchronous active-high reset
//   bus         fetch input (pc/inst), regfile read (rs addr/data/ready),
//               branch_pc redirect to fetch, dec_* forward to decode
// Non-control instructions are forwarded the cycle after capture and may
// stream one per cycle. Control instructions wait in RESOLVE for operands,
// then present branch_pc and the decode pair together in SEND until both
// have transferred.
// ---------------------------------------------------------------------------
module pyrm_branch_unit
   import pyrm_pkg::*;
(
   input  logic             clk,
   input  logic             reset_pyri,
   pyrm_branch_unit_if.slave bus
);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [63:0] r_pc;
   logic [31:0] r_inst;
   logic [63:0] r_target;
   logic        r_br_done;
   logic        r_dec_done;

   logic        w_dec_valid;
   logic        w_br_valid;
   logic        w_dec_xfer;
   logic        w_br_xfer;
   logic        w_send_fin;
   logic        w_retry;
   logic        w_accept;
   logic        w_in_ctl;
   logic [63:0] w_target;
   logic [12:0] w_imm_b;

   always_comb begin
      w_dec_valid = 1'b0;
      w_br_valid  = 1'b0;
      case (r_state)
         ST_HOLD: w_dec_valid = 1'b1;
         ST_SEND: begin
            w_dec_valid = ~r_dec_done;
            w_br_valid  = ~r_br_done;
         end
         default: ;
      endcase
      if (reset_pyri) begin
         w_dec_valid = 1'b0;
         w_br_valid  = 1'b0;
      end
   end

   assign w_dec_xfer = w_dec_valid & ~bus.dec_retry_pyri;
   assign w_br_xfer  = w_br_valid  & ~bus.branch_pc_retry_pyri;
   // Both channels are finished once each has transferred, now or earlier.
   assign w_send_fin = (r_dec_done | w_dec_xfer) & (r_br_done | w_br_xfer);

   // Retry looks only at occupancy and downstream handshakes, never at the
   // incoming valids, so fetch sees no combinational loop through us.
   always_comb begin
      w_retry = 1'b1;
      case (r_state)
         ST_EMPTY:   w_retry = 1'b0;
         ST_HOLD:    w_retry = ~w_dec_xfer;
         ST_RESOLVE: w_retry = 1'b1;
         ST_SEND:    w_retry = ~w_send_fin;
         default:    w_retry = 1'b1;
      endcase
      if (reset_pyri) w_retry = 1'b1;
   end

   assign w_accept = bus.pc_valid_pyri & bus.inst_valid_pyri & ~w_retry;
   assign w_in_ctl = is_control(bus.inst_pyri[6:0]);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY:
            if (w_accept) w_state_nxt = w_in_ctl ? ST_RESOLVE : ST_HOLD;
         ST_HOLD:
            if (w_accept)        w_state_nxt = w_in_ctl ? ST_RESOLVE : ST_HOLD;
            else if (w_dec_xfer) w_state_nxt = ST_EMPTY;
         ST_RESOLVE:
            if (bus.rs_ready_pyri) w_state_nxt = ST_SEND;
         ST_SEND:
            if (w_accept)        w_state_nxt = w_in_ctl ? ST_RESOLVE : ST_HOLD;
            else if (w_send_fin) w_state_nxt = ST_EMPTY;
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_pyri) begin
         r_state    <= ST_EMPTY;
         r_br_done  <= 1'b0;
         r_dec_done <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_SEND && !w_send_fin) begin
            r_br_done  <= r_br_done  | w_br_xfer;
            r_dec_done <= r_dec_done | w_dec_xfer;
         end else begin
            r_br_done  <= 1'b0;
            r_dec_done <= 1'b0;
         end
      end
   end

   // Payload registers carry no reset; outputs are masked during reset and
   // the state machine guarantees nothing stale is ever presented as valid.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_pc   <= bus.pc_pyri;
         r_inst <= bus.inst_pyri;
      end
      if (r_state == ST_RESOLVE && bus.rs_ready_pyri) r_target <= w_target;
   end

   assign w_imm_b = {r_inst[31], r_inst[7], r_inst[30:25], r_inst[11:8], 1'b0};

   pyrm_branch_cmp u_cmp (
      .i_pc      (r_pc),
      .i_rs1     (bus.rs1_data_pyri),
      .i_rs2     (bus.rs2_data_pyri),
      .i_is_jalr (r_inst[6:0] == OPC_JALR),
      .i_funct3  (r_inst[14:12]),
      .i_imm_i   (r_inst[31:20]),
      .i_imm_b   (w_imm_b),
      .o_target  (w_target)
   );

   assign bus.pc_retry_pyro        = w_retry;
   assign bus.inst_retry_pyro      = w_retry;
   assign bus.rs1_addr_pyro        = reset_pyri ? 5'd0  : r_inst[19:15];
   assign bus.rs2_addr_pyro        = reset_pyri ? 5'd0  : r_inst[24:20];
   assign bus.branch_pc_pyro       = reset_pyri ? 64'd0 : r_target;
   assign bus.branch_pc_valid_pyro = w_br_valid;
   assign bus.dec_pc_pyro          = reset_pyri ? 64'd0 : r_pc;
   assign bus.dec_inst_pyro        = reset_pyri ? 32'd0 : r_inst;
   assign bus.dec_valid_pyro       = w_dec_valid;

endmodule

// File: tb/tb_pyrm_branch_unit.sv
module tb_pyrm_branch_unit;
   import pyrm_pkg::*;

   logic clk;
   logic reset_pyri;
   int   cyc;
   int   n_checks;
   int   n_pass;
   int   br_count;

   logic [95:0] exp_dec_q[$];
   logic [63:0] exp_br_q[$];
   int          dec_xfer_cyc[$];
   int          br_xfer_cyc[$];

   pyrm_branch_unit_if bus();

   pyrm_branch_unit dut (
      .clk        (clk),
      .reset_pyri (reset_pyri),
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [2:0] f3);
      return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
   endfunction

   // Scoreboard monitor: every transfer must match the oldest expectation.
   always @(negedge clk) begin
      logic [95:0] ed;
      logic [63:0] eb;
      if (bus.dec_valid_pyro && !bus.dec_retry_pyri) begin
         dec_xfer_cyc.push_back(cyc);
         n_checks++;
         if (exp_dec_q.size() == 0)
            $display("FAIL dec_unexpected got pc=%h inst=%h, none expected",
                     bus.dec_pc_pyro, bus.dec_inst_pyro);
         else begin
            ed = exp_dec_q.pop_front();
            if ({bus.dec_pc_pyro, bus.dec_inst_pyro} !== ed)
               $display("FAIL dec_pair got %h_%h expected %h_%h",
                        bus.dec_pc_pyro, bus.dec_inst_pyro, ed[95:32], ed[31:0]);
            else n_pass++;
         end
      end
      if (bus.branch_pc_valid_pyro && !bus.branch_pc_retry_pyri) begin
         br_count++;
         br_xfer_cyc.push_back(cyc);
         n_checks++;
         if (exp_br_q.size() == 0)
            $display("FAIL br_unexpected got %h, none expected", bus.branch_pc_pyro);
         else begin
            eb = exp_br_q.pop_front();
            if (bus.branch_pc_pyro !== eb)
               $display("FAIL branch_pc got %h expected %h", bus.branch_pc_pyro, eb);
            else n_pass++;
         end
      end
   end

   task automatic idle();
      bus.pc_valid_pyri   = 1'b0;
      bus.inst_valid_pyri = 1'b0;
   endtask

   // Offer one instruction and hold it until accepted; returns accept cycle.
   task automatic issue(input logic [63:0] pc, input logic [31:0] inst, output int acc_cyc);
      int n;
      logic acc;
      bus.pc_pyri         = pc;
      bus.inst_pyri       = inst;
      bus.pc_valid_pyri   = 1'b1;
      bus.inst_valid_pyri = 1'b1;
      exp_dec_q.push_back({pc, inst});
      acc     = 1'b0;
      n       = 0;
      acc_cyc = -100;
      while (!acc && n < 40) begin
         @(negedge clk);
         if (!bus.pc_retry_pyro) begin
            acc     = 1'b1;
            acc_cyc = cyc;
         end
         @(posedge clk); #1;
         n++;
      end
      if (!acc) begin
         n_checks++;
         $display("FAIL issue_timeout pc=%h not accepted in 40 cycles", pc);
      end
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_dec_q.size() != 0 || exp_br_q.size() != 0) && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      n_checks++;
      if (exp_dec_q.size() != 0 || exp_br_q.size() != 0)
         $display("FAIL %s_drain pending dec=%0d br=%0d required 0/0",
                  name, exp_dec_q.size(), exp_br_q.size());
      else n_pass++;
   endtask

   task automatic test_reset();
      reset_pyri = 1'b1;
      idle();
      bus.pc_pyri = 64'd0; bus.inst_pyri = 32'd0;
      bus.rs1_data_pyri = 64'd0; bus.rs2_data_pyri = 64'd0;
      bus.rs_ready_pyri = 1'b1;
      bus.branch_pc_retry_pyri = 1'b0;
      bus.dec_retry_pyri = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.dec_valid_pyro !== 1'b0 || bus.branch_pc_valid_pyro !== 1'b0)
         $display("FAIL reset_valids got dec=%b br=%b required 0/0",
                  bus.dec_valid_pyro, bus.branch_pc_valid_pyro);
      else n_pass++;
      n_checks++;
      if (bus.pc_retry_pyro !== 1'b1 || bus.inst_retry_pyro !== 1'b1)
         $display("FAIL reset_retry got %b/%b required 1/1",
                  bus.pc_retry_pyro, bus.inst_retry_pyro);
      else n_pass++;
      n_checks++;
      if (bus.dec_pc_pyro !== 64'd0 || bus.dec_inst_pyro !== 32'd0 || bus.branch_pc_pyro !== 64'd0)
         $display("FAIL reset_data got dec_pc=%h dec_inst=%h br=%h required zeros",
                  bus.dec_pc_pyro, bus.dec_inst_pyro, bus.branch_pc_pyro);
      else n_pass++;
      @(posedge clk); #1;
      reset_pyri = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.pc_retry_pyro !== 1'b0)
         $display("FAIL empty_retry got %b required 0", bus.pc_retry_pyro);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int a0, a1, a2, br0;
      dec_xfer_cyc.delete();
      br0 = br_count;
      issue(RESET_PC,          enc_i(12'd1, 5'd0, 3'b000, 5'd1, 7'b0010011), a0);
      issue(RESET_PC + 64'd4,  enc_i(12'd2, 5'd0, 3'b000, 5'd2, 7'b0010011), a1);
      issue(RESET_PC + 64'd8,  enc_i(12'd3, 5'd0, 3'b000, 5'd3, 7'b0010011), a2);
      idle();
      n_checks++;
      if (a1 !== a0 + 1 || a2 !== a0 + 2)
         $display("FAIL b2b_accept got cycles %0d,%0d,%0d required consecutive", a0, a1, a2);
      else n_pass++;
      wait_drain("b2b");
      n_checks++;
      if (dec_xfer_cyc.size() != 3 || dec_xfer_cyc[0] != a0 + 1 ||
          dec_xfer_cyc[1] != a0 + 2 || dec_xfer_cyc[2] != a0 + 3)
         $display("FAIL b2b_dec_timing got %0d transfers first at %0d required 3 from %0d",
                  dec_xfer_cyc.size(), (dec_xfer_cyc.size() > 0) ? dec_xfer_cyc[0] : -1, a0 + 1);
      else n_pass++;
      n_checks++;
      if (br_count !== br0)
         $display("FAIL b2b_no_branch got %0d branch transfers required 0", br_count - br0);
      else n_pass++;
   endtask

   task automatic test_noncontrol();
      int a, b, br0;
      br0 = br_count;
      bus.dec_retry_pyri = 1'b1;
      issue(64'h8000_0400, enc_i(12'h010, 5'd0, 3'b000, 5'd1, 7'b1101111), a);
      bus.pc_pyri = 64'h8000_0404; bus.inst_pyri = 32'h0000_0000;
      @(negedge clk);
      n_checks++;
      if (bus.pc_retry_pyro !== 1'b1 || bus.dec_valid_pyro !== 1'b1 || bus.dec_pc_pyro !== 64'h8000_0400)
         $display("FAIL hold_stall got retry=%b dec_valid=%b dec_pc=%h required 1/1/80000400",
                  bus.pc_retry_pyro, bus.dec_valid_pyro, bus.dec_pc_pyro);
      else n_pass++;
      @(posedge clk); #1;
      bus.dec_retry_pyri = 1'b0;
      issue(64'h8000_0404, 32'h0000_0000, b);
      idle();
      n_checks++;
      if (b !== a + 2)
         $display("FAIL hold_release got accept cycle %0d required %0d", b, a + 2);
      else n_pass++;
      wait_drain("noncontrol");
      n_checks++;
      if (br_count !== br0)
         $display("FAIL jal_no_branch got %0d branch transfers required 0", br_count - br0);
      else n_pass++;
   endtask

   task automatic test_beq();
      int a;
      bus.rs1_data_pyri = 64'd5; bus.rs2_data_pyri = 64'd5; bus.rs_ready_pyri = 1'b1;
      br_xfer_cyc.delete();
      exp_br_q.push_back(64'h8000_0020);
      issue(64'h8000_0010, enc_b(13'd16, 5'd1, 5'd2, F3_BEQ), a);
      idle();
      @(negedge clk);
      n_checks++;
      if (bus.rs1_addr_pyro !== 5'd1 || bus.rs2_addr_pyro !== 5'd2)
         $display("FAIL rs_addr got %0d/%0d required 1/2", bus.rs1_addr_pyro, bus.rs2_addr_pyro);
      else n_pass++;
      wait_drain("beq_taken");
      n_checks++;
      if (br_xfer_cyc.size() != 1 || br_xfer_cyc[0] != a + 2)
         $display("FAIL beq_latency got %0d transfers at %0d required 1 at %0d",
                  br_xfer_cyc.size(), (br_xfer_cyc.size() > 0) ? br_xfer_cyc[0] : -1, a + 2);
      else n_pass++;
      bus.rs2_data_pyri = 64'd6;
      exp_br_q.push_back(64'h8000_0014);
      issue(64'h8000_0010, enc_b(13'd16, 5'd1, 5'd2, F3_BEQ), a);
      idle();
      wait_drain("beq_not_taken");
   endtask

   task automatic test_compare();
      int a;
      bus.rs1_data_pyri = 64'hFFFF_FFFF_FFFF_FFFF; bus.rs2_data_pyri = 64'd1;
      exp_br_q.push_back(64'h8000_0110);
      issue(64'h8000_0100, enc_b(13'd16, 5'd1, 5'd2, F3_BLT), a);
      idle();
      wait_drain("blt");
      exp_br_q.push_back(64'h8000_0104);
      issue(64'h8000_0100, enc_b(13'd16, 5'd1, 5'd2, F3_BLTU), a);
      idle();
      wait_drain("bltu");
      bus.rs2_data_pyri = 64'hFFFF_FFFF_FFFF_FFFF;
      exp_br_q.push_back(64'h8000_0104);
      issue(64'h8000_0100, enc_b(13'd16, 5'd1, 5'd2, 3'b010), a);
      idle();
      wait_drain("f3_010");
      // Backward branch crossing zero wraps modulo 2^64.
      exp_br_q.push_back(64'hFFFF_FFFF_FFFF_FFF8);
      issue(64'h0000_0000_0000_0008, enc_b(13'h1FF0, 5'd1, 5'd2, F3_BGEU), a);
      idle();
      wait_drain("bgeu_wrap");
   endtask

   task automatic test_jalr();
      int a, rc;
      bus.rs1_data_pyri = 64'h8000_1000; bus.rs_ready_pyri = 1'b0;
      br_xfer_cyc.delete();
      exp_br_q.push_back(64'h8000_1002);
      issue(64'h8000_0300, enc_i(12'd3, 5'd1, 3'b000, 5'd0, OPC_JALR), a);
      idle();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.branch_pc_valid_pyro !== 1'b0 || bus.dec_valid_pyro !== 1'b0)
            $display("FAIL jalr_wait got br_valid=%b dec_valid=%b required 0/0",
                     bus.branch_pc_valid_pyro, bus.dec_valid_pyro);
         else n_pass++;
         @(posedge clk); #1;
      end
      bus.rs_ready_pyri = 1'b1;
      rc = cyc;
      wait_drain("jalr");
      n_checks++;
      if (br_xfer_cyc.size() != 1 || br_xfer_cyc[0] != rc + 1)
         $display("FAIL jalr_latency got %0d transfers at %0d required 1 at %0d",
                  br_xfer_cyc.size(), (br_xfer_cyc.size() > 0) ? br_xfer_cyc[0] : -1, rc + 1);
      else n_pass++;
   endtask

   task automatic test_bne_stall();
      int a, br0;
      bus.rs1_data_pyri = 64'd5; bus.rs2_data_pyri = 64'd6; bus.rs_ready_pyri = 1'b1;
      bus.branch_pc_retry_pyri = 1'b1;
      br0 = br_count;
      exp_br_q.push_back(64'h8000_0210);
      issue(64'h8000_0200, enc_b(13'd16, 5'd1, 5'd2, F3_BNE), a);
      bus.pc_pyri   = 64'h8000_0210;
      bus.inst_pyri = enc_i(12'd7, 5'd0, 3'b000, 5'd5, 7'b0010011);
      exp_dec_q.push_back({bus.pc_pyri, bus.inst_pyri});
      @(negedge clk);
      n_checks++;
      if (bus.pc_retry_pyro !== 1'b1)
         $display("FAIL resolve_retry got %b required 1", bus.pc_retry_pyro);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         n_checks++;
         if (bus.branch_pc_valid_pyro !== 1'b1 || bus.branch_pc_pyro !== 64'h8000_0210 ||
             bus.pc_retry_pyro !== 1'b1 || bus.inst_retry_pyro !== 1'b1)
            $display("FAIL bne_stall got valid=%b pc=%h retry=%b/%b required 1/80000210/1/1",
                     bus.branch_pc_valid_pyro, bus.branch_pc_pyro,
                     bus.pc_retry_pyro, bus.inst_retry_pyro);
         else n_pass++;
      end
      @(posedge clk); #1;
      bus.branch_pc_retry_pyri = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.pc_retry_pyro !== 1'b0)
         $display("FAIL send_release got retry=%b required 0", bus.pc_retry_pyro);
      else n_pass++;
      @(posedge clk); #1;
      idle();
      wait_drain("bne");
      n_checks++;
      if (br_count !== br0 + 1)
         $display("FAIL bne_once got %0d branch transfers required 1", br_count - br0);
      else n_pass++;
   endtask

   task automatic test_reset_in_send();
      int a, br0, d0;
      bus.rs1_data_pyri = 64'd5; bus.rs2_data_pyri = 64'd5; bus.rs_ready_pyri = 1'b1;
      bus.branch_pc_retry_pyri = 1'b1; bus.dec_retry_pyri = 1'b1;
      exp_br_q.push_back(64'h8000_0510);
      issue(64'h8000_0500, enc_b(13'd16, 5'd1, 5'd2, F3_BEQ), a);
      idle();
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (bus.branch_pc_valid_pyro !== 1'b1 || bus.dec_valid_pyro !== 1'b1)
         $display("FAIL send_entry got br_valid=%b dec_valid=%b required 1/1",
                  bus.branch_pc_valid_pyro, bus.dec_valid_pyro);
      else n_pass++;
      @(posedge clk); #1;
      reset_pyri = 1'b1;
      exp_dec_q.delete();
      exp_br_q.delete();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.branch_pc_valid_pyro !== 1'b0 || bus.dec_valid_pyro !== 1'b0 ||
             bus.pc_retry_pyro !== 1'b1 || bus.inst_retry_pyro !== 1'b1 ||
             bus.branch_pc_pyro !== 64'd0 || bus.dec_pc_pyro !== 64'd0)
            $display("FAIL reset_send got br_v=%b dec_v=%b retry=%b/%b br=%h dpc=%h required 0/0/1/1/0/0",
                     bus.branch_pc_valid_pyro, bus.dec_valid_pyro, bus.pc_retry_pyro,
                     bus.inst_retry_pyro, bus.branch_pc_pyro, bus.dec_pc_pyro);
         else n_pass++;
         @(posedge clk); #1;
         bus.branch_pc_retry_pyri = 1'b0; bus.dec_retry_pyri = 1'b0;
      end
      reset_pyri = 1'b0;
      br0 = br_count;
      d0  = dec_xfer_cyc.size();
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if (br_count !== br0 || dec_xfer_cyc.size() !== d0)
         $display("FAIL reset_discard got br=%0d dec=%0d transfers required 0/0",
                  br_count - br0, dec_xfer_cyc.size() - d0);
      else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      br_count = 0;
      test_reset();
      test_back_to_back();
      test_noncontrol();
      test_beq();
      test_compare();
      test_jalr();
      test_bne_stall();
      test_reset_in_send();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
